// File: rtl/a0_stream_buffer_if.sv
// a0_stream_buffer_if: valid/ready output stream of the a0 capture buffer.
//   out_valid  head entry available (driven by the buffer)
//   out_ready  sink accepts the head entry (driven by the sink)
//   out_data   head entry value
//   out_stamp  head entry timestamp, present only when A0_STREAM_TIMESTAMP_EN is defined
// Modports: master = buffer side, slave = sink side.
interface a0_stream_buffer_if #(
    parameter int WIDTH = 32,
    parameter int TSW   = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef A0_STREAM_TIMESTAMP_EN
    logic [TSW-1:0]   out_stamp;
`endif

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
`ifdef A0_STREAM_TIMESTAMP_EN
        , output out_stamp
`endif
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
`ifdef A0_STREAM_TIMESTAMP_EN
        , input out_stamp
`endif
    );
endinterface

// File: rtl/a0_stream_buffer.sv
// a0_stream_buffer: watches the CPU a0 tap, queues every new value in a
// first-word-fall-through FIFO and presents it on a valid/ready stream.
// Values arriving while the FIFO is full (and not popping) are dropped and
// counted rather than lost silently.
// Optional feature macro: A0_STREAM_TIMESTAMP_EN (per-entry cycle stamp).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   a0_in       CPU a0_output tap
//   capture_en  enables change detection and push
//   flush       synchronous FIFO clear (keeps overflow/drop_count)
//   out         stream interface (master modport): valid/ready/data[/stamp]
//   count       occupancy 0..DEPTH
//   overflow    sticky: at least one value dropped
//   drop_count  dropped-value count, saturating at 255
module a0_stream_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int TSW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         a0_in,
    input  logic                     capture_en,
    input  logic                     flush,
    a0_stream_buffer_if.master       out,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TSW < 1) begin : g_bad_param
        $error("a0_stream_buffer: DEPTH must be a power of two >= 2 and TSW >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_a0;
    logic             primed;

`ifdef A0_STREAM_TIMESTAMP_EN
    logic [TSW-1:0]   ts_cnt;
    logic [TSW-1:0]   stamp_mem [DEPTH];
`endif

    logic full;
    logic pop;
    logic push_req;
    logic push;
    logic drop;

    always_comb begin
        full     = (count == CW'(DEPTH));
        pop      = out.out_valid && out.out_ready;
        push_req = capture_en && (!primed || a0_in != last_a0);
        // At full, a same-cycle pop frees the slot the push needs.
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;
    end

    assign out.out_valid = (count != '0);
    assign out.out_data  = mem[rd_ptr];
`ifdef A0_STREAM_TIMESTAMP_EN
    assign out.out_stamp = stamp_mem[rd_ptr];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_a0    <= '0;
            primed     <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
`ifdef A0_STREAM_TIMESTAMP_EN
                stamp_mem[i] <= '0;
`endif
            end
`ifdef A0_STREAM_TIMESTAMP_EN
            ts_cnt <= '0;
`endif
        end else begin
`ifdef A0_STREAM_TIMESTAMP_EN
            // Free-running; flush does not touch it.
            ts_cnt <= ts_cnt + 1'b1;
`endif
            if (flush) begin
                // Clearing primed forces the next enabled cycle to re-capture a0_in.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                primed <= 1'b0;
            end else begin
                // last_a0 follows every detected change, even a dropped one,
                // so a stalled sink never causes a value to be queued twice.
                if (push_req) begin
                    last_a0 <= a0_in;
                    primed  <= 1'b1;
                end
                if (push) begin
                    mem[wr_ptr] <= a0_in;
`ifdef A0_STREAM_TIMESTAMP_EN
                    stamp_mem[wr_ptr] <= ts_cnt;
`endif
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_count != 8'hFF) begin
                        drop_count <= drop_count + 8'd1;
                    end
                end
                if (push && !pop) begin
                    count <= count + 1'b1;
                end else if (pop && !push) begin
                    count <= count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_a0_stream_buffer.sv
// tb_a0_stream_buffer: directed stimulus for a0_stream_buffer with a
// queue-based reference model compared every cycle, plus literal
// expectations for the key scenarios (dedup, overflow, flush, stamps).
module tb_a0_stream_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int TSW   = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] a0_in = '0;
    logic             capture_en = 1'b0;
    logic             flush = 1'b0;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [7:0]       drop_count;

    a0_stream_buffer_if #(.WIDTH(WIDTH), .TSW(TSW)) s_if ();

    a0_stream_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TSW(TSW)) dut (
        .clk        (clk),
        .rst        (rst),
        .a0_in      (a0_in),
        .capture_en (capture_en),
        .flush      (flush),
        .out        (s_if.master),
        .count      (count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of (data, stamp) entries.
    typedef struct { logic [WIDTH-1:0] data; int stamp; } entry_t;
    entry_t           mq[$];
    logic [WIDTH-1:0] m_last = '0;
    bit               m_primed = 0;
    bit               m_ovf = 0;
    int               m_drops = 0;
    int               m_ts = 0;
    bit               started = 0;

    always @(posedge clk) begin
        bit m_pop, m_req, m_full;
        started = 1;
        if (rst) begin
            mq.delete();
            m_last = '0; m_primed = 0; m_ovf = 0; m_drops = 0; m_ts = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (mq.size() != 0) && s_if.out_ready;
            m_req  = capture_en && (!m_primed || a0_in != m_last);
            if (flush) begin
                mq.delete();
                m_primed = 0;
            end else begin
                if (m_pop) void'(mq.pop_front());
                if (m_req) begin
                    m_last = a0_in;
                    m_primed = 1;
                    if (!m_full || m_pop) begin
                        entry_t e;
                        e.data = a0_in;
                        e.stamp = m_ts;
                        mq.push_back(e);
                    end else begin
                        m_ovf = 1;
                        if (m_drops < 255) m_drops++;
                    end
                end
            end
            m_ts = (m_ts + 1) % (1 << TSW);
        end
    end

    // Every-cycle comparison plus a log of values actually handed to the sink.
    logic [WIDTH-1:0] popped[$];

    always @(negedge clk) begin
        if (started) begin
            chk("out_valid", s_if.out_valid, mq.size() != 0);
            chk("count", count, mq.size());
            chk("overflow", overflow, m_ovf);
            chk("drop_count", drop_count, m_drops);
            if (mq.size() != 0) begin
                chk("out_data", s_if.out_data, mq[0].data);
`ifdef A0_STREAM_TIMESTAMP_EN
                chk("out_stamp", s_if.out_stamp, mq[0].stamp);
`endif
            end
            if (!rst && !flush && s_if.out_valid && s_if.out_ready)
                popped.push_back(s_if.out_data);
        end
    end

    task automatic step(input logic [WIDTH-1:0] a, input logic cap, input logic rdy,
                        input logic fl, input logic rs);
        a0_in = a;
        capture_en = cap;
        s_if.out_ready = rdy;
        flush = fl;
        rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        s_if.out_ready = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("reset count", count, 0);
        chk("reset valid", s_if.out_valid, 0);
        chk("reset drops", drop_count, 0);

        // First enabled edge captures a0=0 exactly once.
        step(0, 1, 0, 0, 0);
        chk("first valid", s_if.out_valid, 1);
        chk("first data", s_if.out_data, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("no dup count", count, 1);

        // Dedup stream with sink ready.
        popped.delete();
        step(5, 1, 1, 0, 0);
        step(5, 1, 1, 0, 0);
        step(7, 1, 1, 0, 0);
        step(7, 1, 1, 0, 0);
        step(9, 1, 1, 0, 0);
        step(9, 1, 1, 0, 0);
        chk("stream len", popped.size(), 4);
        if (popped.size() == 4) begin
            chk("stream0", popped[0], 0);
            chk("stream1", popped[1], 5);
            chk("stream2", popped[2], 7);
            chk("stream3", popped[3], 9);
        end
        chk("no overflow", overflow, 0);

        // Overflow: DEPTH+3 distinct values into a stalled sink.
        for (int i = 0; i < DEPTH + 3; i++) step(100 + i, 1, 0, 0, 0);
        chk("ovf count", count, DEPTH);
        chk("ovf flag", overflow, 1);
        chk("ovf drops", drop_count, 3);
        popped.delete();
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 0);
        chk("drain len", popped.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < popped.size(); i++) chk("drain order", popped[i], 100 + i);
        chk("drained count", count, 0);

        // Full FIFO: simultaneous push and pop.
        for (int i = 0; i < DEPTH; i++) step(200 + i, 1, 0, 0, 0);
        chk("refill count", count, DEPTH);
        step(300, 1, 1, 0, 0);
        chk("full pp count", count, DEPTH);
        chk("full pp drops", drop_count, 3);
        chk("full pp head", s_if.out_data, 201);

        // Flush with a same-cycle new value; next enabled cycle re-captures.
        step(300, 0, 0, 1, 0);
        chk("flush count", count, 0);
        step(400, 1, 0, 0, 0);
        step(401, 1, 0, 0, 0);
        step(402, 1, 0, 0, 0);
        chk("three queued", count, 3);
        step(403, 1, 0, 1, 0);
        chk("flush2 count", count, 0);
        chk("flush2 valid", s_if.out_valid, 0);
        chk("flush keeps ovf", overflow, 1);
        step(403, 1, 0, 0, 0);
        chk("recapture count", count, 1);
        chk("recapture data", s_if.out_data, 403);

        // Reset mid-operation, then timestamped pushes at edges 3 and 20.
        step(403, 1, 1, 1, 1);
        chk("rst ovf", overflow, 0);
        chk("rst drops", drop_count, 0);
        chk("rst count", count, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        step(11, 1, 0, 0, 0);
        for (int k = 4; k < 20; k++) step(11, 0, 0, 0, 0);
        step(22, 1, 0, 0, 0);
        chk("ts count", count, 2);
        chk("ts data0", s_if.out_data, 11);
`ifdef A0_STREAM_TIMESTAMP_EN
        chk("stamp0", s_if.out_stamp, 3);
`endif
        step(22, 0, 1, 0, 0);
        chk("ts data1", s_if.out_data, 22);
`ifdef A0_STREAM_TIMESTAMP_EN
        chk("stamp1", s_if.out_stamp, 4);
`endif
        step(22, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/a0_stream_buffer.md
# a0_stream_buffer

Downstream consumer of the CPU's `a0_output` register tap. It watches `a0` every cycle, detects value changes, and queues each new value in a small first-word-fall-through FIFO. A valid/ready stream presents the queued values to a display/UART/testbench sink, so no intermediate `a0` result is lost when the sink stalls. Overflow is tracked and reported rather than silently discarded.

## Interface
Parameters:
- `WIDTH`, 32: data width; matches the CPU `a0_output` width.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `TSW`, 16: timestamp width; used only when `A0_STREAM_TIMESTAMP_EN` is defined.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a0_in`  in  WIDTH  connected to the CPU `a0_output`.
- `capture_en`  in  1  change detection and push are enabled only while this is high.
- `flush`  in  1  synchronous FIFO clear.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  sink accepts the head entry.
- `out_data`  out  WIDTH  head entry value.
- `out_stamp`  out  TSW  head entry timestamp; present only with the macro.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky flag: at least one value was dropped.
- `drop_count`  out  8  dropped-value count; saturates at 255.

## Operation
- State:
  - `last_a0` (WIDTH), `primed` (1).
  - Storage `mem[DEPTH]`, with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
  - `count` register.
- Change detect: `push_req = capture_en && (!primed || a0_in != last_a0)`.
  - On `push_req`: `last_a0 <= a0_in` and `primed <= 1`.
  - This update happens even when the push is dropped, so a stalled sink never causes the same value to be re-queued.
- Pop: `pop = out_valid && out_ready`.
- Push acceptance: `push = push_req && (count < DEPTH || pop)`. A simultaneous push and pop at full is legal; `count` stays DEPTH.
- Drop: `push_req && count == DEPTH && !pop`.
  - `overflow <= 1`.
  - `drop_count` increments and saturates at 255.
- Count update: `count` +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Output: `out_valid = (count != 0)`. `out_data = mem[rd_ptr]`.
- Flush:
  - Clears `wr_ptr`, `rd_ptr`, `count` and `primed`.
  - Has priority over any same-cycle push and pop; both are ignored.
  - Does not clear `overflow` or `drop_count`.
- `capture_en` low: no pushes. `last_a0` and `primed` hold. Pops continue.

## Timing
- Reset values:
  - `out_valid` = 0, `count` = 0, `overflow` = 0, `drop_count` = 0.
  - `out_data` = 0 (mem cleared), `out_stamp` = 0.
  - `primed` = 0, `last_a0` = 0, pointers = 0, timestamp counter = 0.
- Latency: a new `a0_in` value present before edge N is pushed at edge N. It appears on `out_data` with `out_valid` = 1 in the cycle after edge N if the FIFO was empty.
- FWFT: `out_data`/`out_stamp` come from registers with no combinational path from `a0_in`. They are held stable while `out_valid && !out_ready`.
- Throughput: one push and one pop per cycle.
- Reset mid-operation: `rst` overrides `flush` and all traffic. Everything returns to reset values in one edge.

## Configuration
- `A0_STREAM_TIMESTAMP_EN` defined:
  - A free-running TSW-bit cycle counter runs from reset, wraps at 2^TSW, and is not affected by `flush`.
  - Each entry stores the counter value at its push edge. The stored value is presented on `out_stamp`.
- Not defined: no counter, no stamp storage, and no `out_stamp` port.

## Test plan
- Reset, then `capture_en` = 1 with `a0_in` = 0 held → exactly one entry with data 0. `out_valid` rises one cycle after the first enabled edge, and `count` = 1.
- `a0_in` sequence 5, 5, 7, 7, 9 with `out_ready` = 1 → stream 0(first), 5, 7, 9. There are no duplicates and `overflow` stays 0.
- `out_ready` = 0 and DEPTH+3 distinct values → `count` = DEPTH, `overflow` = 1, `drop_count` = 3. Draining yields the first DEPTH values in order.
- Full FIFO with a new value and `out_ready` = 1 in the same cycle → pop and push both occur, `count` stays DEPTH, `drop_count` is unchanged.
- Three entries queued, then `flush` asserted in the same cycle as a new value → `count` = 0 and `out_valid` = 0 next cycle. The next enabled cycle pushes the current `a0_in` (`primed` was cleared).
- With `A0_STREAM_TIMESTAMP_EN`, TSW = 4: push values at cycles 3 and 20 after reset → stamps 3 and 4 (20 mod 16).
